vram_arbiter: RTL and testbench

- Shares one synchronous single-port frame-buffer RAM between two requesters: the VGA scan-out path (strict priority) and the CPU bus port (req/ack).
- Sits between the 25 MHz VGA timing block (source of the read strobe and h/v pixel addresses) and the CPU bus bridge.
- Generates the RAM address from the display coordinates with optional pixel down-scaling.
- Grants the CPU the RAM cycles the display does not need.

---
 rtl/vram_pkg.sv | 20 ++
 rtl/vram_addr_gen.sv | 29 ++
 rtl/vram_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter and its frame-buffer helpers:
// active display size, CPU access FSM states and frame-size helper.
package vram_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    ACK   = 2'd3
  } cpu_state_e;

  // Number of stored pixels once each axis is divided by 2^scale.
  function automatic int frame_size(input int scale);
    return (H_ACTIVE >> scale) * (V_ACTIVE >> scale);
  endfunction

endpackage

// File: rtl/vram_addr_gen.sv
// Maps display coordinates to a linear frame-buffer address:
//   addr = (v >> SCALE) * (640 >> SCALE) + (h >> SCALE), modulo 2^ADDR_W.
// The line length 640 = 512 + 128, so the row product is two shifted copies
// of the row index added together; no multiplier is needed.
module vram_addr_gen
  import vram_pkg::*;
#(
  parameter int SCALE  = 1,
  parameter int ADDR_W = 17
) (
  input  logic [9:0]        h,
  input  logic [8:0]        v,
  output logic [ADDR_W-1:0] addr
);

  localparam int SH_HI = 9 - SCALE;
  localparam int SH_LO = 7 - SCALE;

  logic [ADDR_W-1:0] row_s;
  logic [ADDR_W-1:0] col_s;

  // Shift-add address mapping, truncated to the RAM address width.
  always_comb begin
    row_s = ADDR_W'(v >> SCALE);
    col_s = ADDR_W'(h >> SCALE);
    addr  = (row_s << SH_HI) + (row_s << SH_LO) + col_s;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: display scan-out has strict priority,
// the CPU req/ack port gets the remaining RAM cycles.
// RAM control outputs are combinational so a display read issued in the
// strobe cycle returns its pixel on disp_rgb exactly two cycles later.
// Optional feature: define VRAM_POSTED_WRITE_EN for a 1-entry posted write
// buffer (early write ack, drained in the next free RAM cycle).
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int SCALE  = 1,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              disp_read,
  input  logic [9:0]        disp_h,
  input  logic [8:0]        disp_v,
  output logic [DATA_W-1:0] disp_rgb,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [9:0]  H_MASK    = 10'((1 << SCALE) - 1);
  localparam logic [31:0] FRAME_LIM = 32'(frame_size(SCALE));

  cpu_state_e        state_q, state_d;
  logic              run_q, run_d;      // low only in the first cycle after reset
  logic              rd1_q, rd1_d;      // active pixel one cycle ago
  logic              slot1_q, slot1_d;  // display slot one cycle ago
  logic [DATA_W-1:0] pixel_q, pixel_d;
  logic [DATA_W-1:0] rgb_q, rgb_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
`ifdef VRAM_POSTED_WRITE_EN
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
`endif

  logic              slot_s;
  logic              in_range_s;
  logic [ADDR_W-1:0] disp_addr_s;
  logic              mem_en_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  vram_addr_gen #(
    .SCALE  (SCALE),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .h    (disp_h),
    .v    (disp_v),
    .addr (disp_addr_s)
  );

  // Replicated pixels (low SCALE bits of h non-zero) reuse the last fetch.
  assign slot_s     = run_q & disp_read & ((disp_h & H_MASK) == 10'd0);
  assign in_range_s = (32'(cpu_addr) < FRAME_LIM);

  // Display pipe: latch RAM data after a slot, blank when no active pixel.
  always_comb begin
    run_d   = 1'b1;
    rd1_d   = run_q & disp_read;
    slot1_d = slot_s;
    if (slot1_q) begin
      pixel_d = mem_rdata;
    end else begin
      pixel_d = pixel_q;
    end
    if (rd1_q) begin
      rgb_d = pixel_d;
    end else begin
      rgb_d = {DATA_W{1'b0}};
    end
  end

  // RAM cycle ownership and CPU FSM next state; display always wins.
  always_comb begin
    state_d     = state_q;
    cpu_rdata_d = cpu_rdata_q;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
`ifdef VRAM_POSTED_WRITE_EN
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
`endif
    if (slot_s) begin
      mem_en_s   = 1'b1;
      mem_addr_s = disp_addr_s;
    end
`ifdef VRAM_POSTED_WRITE_EN
    else if (wb_valid_q) begin
      // The FSM never issues while the buffer is full, so drains never collide.
      mem_en_s    = 1'b1;
      mem_we_s    = 1'b1;
      mem_addr_s  = wb_addr_q;
      mem_wdata_s = wb_data_q;
      wb_valid_d  = 1'b0;
    end
`endif
    else begin
      mem_en_s = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
`ifdef VRAM_POSTED_WRITE_EN
        if (wb_valid_q) begin
          // Hold reads and writes until the pending write reaches RAM.
          state_d = WAIT;
        end else if (cpu_we && in_range_s) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = cpu_addr;
          wb_data_d  = cpu_wdata;
          state_d    = ACK;
        end else
`endif
        if (!in_range_s) begin
          // Out-of-range access: no RAM cycle, still acked on the normal path.
          state_d = ISSUE;
        end else if (!slot_s) begin
          mem_en_s    = 1'b1;
          mem_we_s    = cpu_we;
          mem_addr_s  = cpu_addr;
          mem_wdata_s = cpu_wdata;
          state_d     = ISSUE;
        end else begin
          state_d = WAIT;
        end
      end
      ISSUE: begin
        state_d = ACK;
        if (!cpu_we && in_range_s) begin
          cpu_rdata_d = mem_rdata;
        end else begin
          cpu_rdata_d = {DATA_W{1'b0}};
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops any pending CPU access.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      rd1_q       <= 1'b0;
      slot1_q     <= 1'b0;
      pixel_q     <= {DATA_W{1'b0}};
      rgb_q       <= {DATA_W{1'b0}};
      cpu_rdata_q <= {DATA_W{1'b0}};
`ifdef VRAM_POSTED_WRITE_EN
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= {ADDR_W{1'b0}};
      wb_data_q   <= {DATA_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      rd1_q       <= rd1_d;
      slot1_q     <= slot1_d;
      pixel_q     <= pixel_d;
      rgb_q       <= rgb_d;
      cpu_rdata_q <= cpu_rdata_d;
`ifdef VRAM_POSTED_WRITE_EN
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
`endif
    end
  end

  assign mem_en    = mem_en_s;
  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;
  assign disp_rgb  = rgb_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = (state_q == ACK);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: one instance with SCALE=1 (17-bit
// addresses) and one with SCALE=0 (19-bit addresses), each with its own RAM.
// Honours VRAM_POSTED_WRITE_EN for the expected write-ack timing.
`define CHECK(tag, obs, exp) begin n_cmp++; assert ((obs) === (exp)) else begin n_err++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end end

module tb_vram_arbiter;

`ifdef VRAM_POSTED_WRITE_EN
  localparam int WR_LAT = 2;
`else
  localparam int WR_LAT = 3;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  // SCALE=1 instance signals
  logic        a_disp_read, a_cpu_req, a_cpu_we, a_cpu_ack, a_mem_en, a_mem_we;
  logic [9:0]  a_disp_h;
  logic [8:0]  a_disp_v;
  logic [11:0] a_disp_rgb, a_cpu_wdata, a_cpu_rdata, a_mem_wdata, a_mem_rdata;
  logic [16:0] a_cpu_addr, a_mem_addr;
  // SCALE=0 instance signals
  logic        b_disp_read, b_cpu_req, b_cpu_we, b_cpu_ack, b_mem_en, b_mem_we;
  logic [9:0]  b_disp_h;
  logic [8:0]  b_disp_v;
  logic [11:0] b_disp_rgb, b_cpu_wdata, b_cpu_rdata, b_mem_wdata, b_mem_rdata;
  logic [18:0] b_cpu_addr, b_mem_addr;
  // RAM preload ports
  logic        pl_a_en, pl_b_en;
  logic [16:0] pl_a_addr;
  logic [18:0] pl_b_addr;
  logic [11:0] pl_a_data, pl_b_data;

  logic [11:0] ram_a [0:131071];
  logic [11:0] ram_b [0:524287];

  vram_arbiter #(.SCALE(1), .ADDR_W(17), .DATA_W(12)) u_dut_a (
    .clk(clk), .clrn(clrn), .disp_read(a_disp_read), .disp_h(a_disp_h), .disp_v(a_disp_v),
    .disp_rgb(a_disp_rgb), .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
    .cpu_wdata(a_cpu_wdata), .cpu_rdata(a_cpu_rdata), .cpu_ack(a_cpu_ack), .mem_en(a_mem_en),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  vram_arbiter #(.SCALE(0), .ADDR_W(19), .DATA_W(12)) u_dut_b (
    .clk(clk), .clrn(clrn), .disp_read(b_disp_read), .disp_h(b_disp_h), .disp_v(b_disp_v),
    .disp_rgb(b_disp_rgb), .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack), .mem_en(b_mem_en),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Synchronous single-port RAM for instance a, with a preload port.
  always @(posedge clk) begin
    if (pl_a_en) ram_a[pl_a_addr] <= pl_a_data;
    else if (a_mem_en) begin
      if (a_mem_we) ram_a[a_mem_addr] <= a_mem_wdata;
      else a_mem_rdata <= ram_a[a_mem_addr];
    end
  end

  // Synchronous single-port RAM for instance b, with a preload port.
  always @(posedge clk) begin
    if (pl_b_en) ram_b[pl_b_addr] <= pl_b_data;
    else if (b_mem_en) begin
      if (b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
      else b_mem_rdata <= ram_b[b_mem_addr];
    end
  end

  task automatic preload_a(input logic [16:0] addr, input logic [11:0] data);
    @(negedge clk);
    pl_a_en = 1'b1; pl_a_addr = addr; pl_a_data = data;
    @(negedge clk);
    pl_a_en = 1'b0;
  endtask

  // One CPU transaction on instance a; leaves cpu_req high after the ack.
  task automatic txn_a(input logic we, input logic [16:0] addr, input logic [11:0] wdata,
                       output logic [11:0] rdata, output int lat, output logic saw_en);
    logic got;
    got = 1'b0; lat = 0; saw_en = 1'b0; rdata = 12'h000;
    @(negedge clk);
    a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wdata; a_cpu_req = 1'b1;
    for (int i = 0; i < 1000 && !got; i++) begin
      #2;
      saw_en = saw_en | a_mem_en;
      if (a_cpu_ack === 1'b1) begin
        got = 1'b1;
        rdata = a_cpu_rdata;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    `CHECK("txn_a_ack_seen", got, 1'b1)
  endtask

  task automatic idle_a();
    @(negedge clk);
    a_cpu_req = 1'b0; a_cpu_we = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] rd;
    int lat;
    logic saw;
    int bad;

    clrn = 1'b0;
    a_disp_read = 1'b1; a_disp_h = 10'd0; a_disp_v = 9'd0;
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 17'd0; a_cpu_wdata = 12'h000;
    b_disp_read = 1'b0; b_disp_h = 10'd0; b_disp_v = 9'd0;
    b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = 19'd0; b_cpu_wdata = 12'h000;
    pl_a_en = 1'b0; pl_a_addr = 17'd0; pl_a_data = 12'h000;
    pl_b_en = 1'b0; pl_b_addr = 19'd0; pl_b_data = 12'h000;

    // Preload while reset is held (request and display strobe both active).
    preload_a(17'd641, 12'hABC);
    preload_a(17'd0, 12'h123);
    preload_a(17'd76800, 12'hFFF);
    preload_a(17'd76801, 12'hEEE);
    preload_a(17'd200, 12'h0DD);
    @(negedge clk);
    pl_b_en = 1'b1; pl_b_addr = 19'd5000; pl_b_data = 12'h321;
    @(negedge clk);
    pl_b_en = 1'b0;

    // Reset state
    #2;
    `CHECK("rst_disp_rgb", a_disp_rgb, 12'h000)
    `CHECK("rst_cpu_rdata", a_cpu_rdata, 12'h000)
    `CHECK("rst_cpu_ack", a_cpu_ack, 1'b0)
    `CHECK("rst_mem_en", a_mem_en, 1'b0)
    `CHECK("rst_mem_we", a_mem_we, 1'b0)
    `CHECK("rst_mem_addr", a_mem_addr, 17'd0)
    `CHECK("rst_mem_wdata", a_mem_wdata, 12'h000)

    // Release with read of addr 0 pending: ack exactly 3 cycles later
    @(negedge clk); clrn = 1'b1; a_disp_read = 1'b0; #2;
    `CHECK("rel_ack_c0", a_cpu_ack, 1'b0)
    `CHECK("rel_mem_en_c0", a_mem_en, 1'b0)
    @(negedge clk); #2;
    `CHECK("rel_ack_c1", a_cpu_ack, 1'b0)
    `CHECK("rel_issue_en", a_mem_en, 1'b1)
    `CHECK("rel_issue_addr", a_mem_addr, 17'd0)
    @(negedge clk); #2;
    `CHECK("rel_ack_c2", a_cpu_ack, 1'b0)
    @(negedge clk); #2;
    `CHECK("rel_ack_c3", a_cpu_ack, 1'b1)
    `CHECK("rel_rdata", a_cpu_rdata, 12'h123)
    @(negedge clk); a_cpu_req = 1'b0; #2;
    `CHECK("rel_ack_c4", a_cpu_ack, 1'b0)

    // Display address and 2-cycle latency, SCALE=1
    @(negedge clk); a_disp_read = 1'b1; a_disp_h = 10'd2; a_disp_v = 9'd5; #2;
    `CHECK("disp_slot_en", a_mem_en, 1'b1)
    `CHECK("disp_slot_addr", a_mem_addr, 17'd641)
    `CHECK("disp_slot_we", a_mem_we, 1'b0)
    @(negedge clk); a_disp_h = 10'd3; #2;
    `CHECK("disp_repl_no_en", a_mem_en, 1'b0)
    @(negedge clk); a_disp_read = 1'b0; #2;
    `CHECK("disp_rgb_lat2", a_disp_rgb, 12'hABC)
    @(negedge clk); #2;
    `CHECK("disp_rgb_repl", a_disp_rgb, 12'hABC)
    @(negedge clk); #2;
    `CHECK("disp_rgb_blank", a_disp_rgb, 12'h000)

    // Contention: write 100 <- 5A5 while the line is active
    @(negedge clk);
    a_disp_read = 1'b1; a_disp_v = 9'd0; a_disp_h = 10'd19;
    a_cpu_we = 1'b1; a_cpu_addr = 17'd100; a_cpu_wdata = 12'h5A5; a_cpu_req = 1'b1; #2;
    `CHECK("cont_c0_en", a_mem_en, 1'b0)
    @(negedge clk); a_disp_h = 10'd20; #2;
    `CHECK("cont_c1_we", a_mem_we, 1'b0)
    `CHECK("cont_c1_addr", a_mem_addr, 17'd10)
    @(negedge clk); a_disp_h = 10'd21; #2;
    `CHECK("cont_c2_we", a_mem_we, 1'b1)
    `CHECK("cont_c2_addr", a_mem_addr, 17'd100)
    `CHECK("cont_c2_wdata", a_mem_wdata, 12'h5A5)
`ifdef VRAM_POSTED_WRITE_EN
    `CHECK("cont_c2_ack", a_cpu_ack, 1'b1)
    @(negedge clk); a_disp_h = 10'd22; a_cpu_req = 1'b0; #2;
`else
    `CHECK("cont_c2_ack", a_cpu_ack, 1'b0)
    @(negedge clk); a_disp_h = 10'd22; #2;
`endif
    `CHECK("cont_c3_we", a_mem_we, 1'b0)
    `CHECK("cont_c3_addr", a_mem_addr, 17'd11)
    `CHECK("cont_c3_ack", a_cpu_ack, 1'b0)
    @(negedge clk); a_disp_h = 10'd23; #2;
`ifdef VRAM_POSTED_WRITE_EN
    `CHECK("cont_c4_ack", a_cpu_ack, 1'b0)
`else
    `CHECK("cont_c4_ack", a_cpu_ack, 1'b1)
`endif
    @(negedge clk); a_disp_read = 1'b0; a_cpu_req = 1'b0; a_cpu_we = 1'b0; #2;
    `CHECK("cont_ram_100", ram_a[100], 12'h5A5)

    // Readback of addr 100
    txn_a(1'b0, 17'd100, 12'h000, rd, lat, saw);
    `CHECK("rb_rdata", rd, 12'h5A5)
    `CHECK("rb_latency", lat, 3)
    idle_a();

    // Out-of-range read and write, SCALE=1 frame is 76800 pixels
    txn_a(1'b0, 17'd76800, 12'h000, rd, lat, saw);
    `CHECK("oor_rd_rdata", rd, 12'h000)
    `CHECK("oor_rd_no_en", saw, 1'b0)
    `CHECK("oor_rd_latency", lat, 3)
    idle_a();
    txn_a(1'b1, 17'd76801, 12'h111, rd, lat, saw);
    `CHECK("oor_wr_no_en", saw, 1'b0)
    `CHECK("oor_wr_latency", lat, 3)
    idle_a();
    `CHECK("oor_wr_ram_untouched", ram_a[76801], 12'hEEE)

    // Write addr 7 then an immediate read of addr 7
    txn_a(1'b1, 17'd7, 12'h777, rd, lat, saw);
    `CHECK("raw_wr_latency", lat, WR_LAT)
    txn_a(1'b0, 17'd7, 12'h000, rd, lat, saw);
    `CHECK("raw_rd_latency", lat, 3)
    `CHECK("raw_rd_rdata", rd, 12'h777)
    idle_a();

    // Reset in the middle of a pending write: no RAM write, no ack
    @(negedge clk);
    a_cpu_we = 1'b1; a_cpu_addr = 17'd200; a_cpu_wdata = 12'hEEE; a_cpu_req = 1'b1;
    @(negedge clk); clrn = 1'b0; a_cpu_req = 1'b0; #2;
    `CHECK("midrst_mem_en", a_mem_en, 1'b0)
    `CHECK("midrst_ack_c1", a_cpu_ack, 1'b0)
    @(negedge clk); clrn = 1'b1; #2;
    `CHECK("midrst_ack_c2", a_cpu_ack, 1'b0)
    @(negedge clk); #2;
    `CHECK("midrst_ack_c3", a_cpu_ack, 1'b0)
    @(negedge clk); #2;
    `CHECK("midrst_ack_c4", a_cpu_ack, 1'b0)
    `CHECK("midrst_ram_200", ram_a[200], 12'h0DD)

    // Starvation, SCALE=0: display owns every cycle of the active line
    bad = 0;
    b_disp_read = 1'b1; b_disp_v = 9'd3;
    b_cpu_we = 1'b0; b_cpu_addr = 19'd5000;
    for (int h = 10; h < 640; h++) begin
      @(negedge clk);
      b_disp_h = 10'(h);
      if (h == 10) b_cpu_req = 1'b1;
      #2;
      if (b_mem_en !== 1'b1 || b_mem_we !== 1'b0 || b_mem_addr !== 19'(1920 + h) || b_cpu_ack !== 1'b0) bad++;
    end
    `CHECK("starve_display_owns", bad, 0)
    @(negedge clk); b_disp_read = 1'b0; b_disp_h = 10'd640; #2;
    `CHECK("starve_issue_en", b_mem_en, 1'b1)
    `CHECK("starve_issue_addr", b_mem_addr, 19'd5000)
    `CHECK("starve_ack_b0", b_cpu_ack, 1'b0)
    @(negedge clk); #2;
    `CHECK("starve_ack_b1", b_cpu_ack, 1'b0)
    @(negedge clk); #2;
    `CHECK("starve_ack_b2", b_cpu_ack, 1'b1)
    `CHECK("starve_rdata", b_cpu_rdata, 12'h321)
    @(negedge clk); b_cpu_req = 1'b0;

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
